bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Self-sequenced binary-to-BCD converter (shift-and-add-3 / double-dabble).
//  Owns its control FSM, so callers no longer drive shift/adjust strobes.
//  Widths, digit count and signed mode are parameters. Start/done handshake.
//  Sits between the calculator ALU result and the 7-segment display driver.
// PARAMETERS
//  BIN_WIDTH    16  width of the binary operand (2..32)
//  DIGITS        5  BCD digits produced; bcd_out is 4*DIGITS bits
//  SIGNED_MODE   0  1: input is two's complement; magnitude converted, sign on negative
// PORTS
//  clock        in   1            rising-edge clock, single clock domain
//  reset_n      in   1            asynchronous, active-low reset
//  start        in   1            request; sampled only in IDLE or DONE
//  input_data   in   BIN_WIDTH    operand, captured on the accepting edge only
//  busy         out  1            high in ADJUST/SHIFT
//  done         out  1            one-cycle pulse; result valid from this cycle
//  bcd_out      out  4*DIGITS     packed BCD, digit 0 in [3:0]; held until next done
//  negative     out  1            sign of last result (always 0 if SIGNED_MODE=0)
//  overflow     out  1            last result exceeded 10^DIGITS-1; bcd_out = low digits
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; busy, done, negative, overflow = 0;
//    bcd_out = 0; internal shift register and bit counter cleared.
//  - States: IDLE, ADJUST, SHIFT, DONE.
//    IDLE  : start=1 -> load, go ADJUST; otherwise stay.
//    ADJUST: every BCD digit >=5 gets +3 (all digits in parallel) -> SHIFT.
//    SHIFT : {bcd,bin} <<= 1, counter++; counter==BIN_WIDTH -> DONE, else ADJUST.
//    DONE  : done=1 for exactly this cycle; start=1 -> load, go ADJUST
//            (back-to-back); else -> IDLE.
//  - Load: bin part <= magnitude of input_data; bcd part <= 0; counter <= 0;
//    overflow flag cleared; sign latched (SIGNED_MODE=1 and input MSB=1).
//    Magnitude = two's-complement negation, computed in BIN_WIDTH bits unsigned,
//    so the most-negative value (e.g. 16'h8000) yields 32768, not a wrap.
//  - Latency: accepting edge at cycle 0 -> done high in cycle 2*BIN_WIDTH+1
//    (33 for BIN_WIDTH=16). Throughput one result per 2*BIN_WIDTH+1 cycles.
//  - bcd_out, negative, overflow register on the SHIFT->DONE transition only;
//    they never show partial values and stay stable while busy.
//  - Overflow: any 1 shifted out of the top digit's MSB sets a sticky internal
//    flag, published at DONE. For DIGITS >= ceil(BIN_WIDTH*log10(2)) it can never set.
//  - start while busy: ignored, no queueing, input_data not sampled.
//  - Reset mid-conversion: conversion abandoned, no done pulse, outputs zeroed.
//  - Adjust uses a 4-bit add; a digit in 5..9 maps to 8..12, so no carry into the next digit.
// STRUCTURE
//  - Shared package bin2bcd_pkg: state encoding (IDLE=0, ADJUST=1, SHIFT=2,
//    DONE=3, 2-bit), ADD3_THRESHOLD=4'd5, ADD3_VALUE=4'd3.
//  - Sub-module bcd_digit_adjust: combinational 4-bit in -> 4-bit out add-3
//    cell, instantiated DIGITS times with a generate loop.
//  - Top: FSM, $clog2(BIN_WIDTH+1)-bit counter, (4*DIGITS+BIN_WIDTH)-bit
//    shift register, overflow sticky flag, output registers.
// TESTING
//  1. Defaults, input_data=16'd65535, start 1 cycle -> done at cycle 33,
//     bcd_out=20'h65535, overflow=0, negative=0, busy high in cycles 1..32.
//  2. Defaults, inputs 0, 9, 10, 9999 -> bcd_out 20'h00000, 20'h00009,
//     20'h00010, 20'h09999. Random sweep vs. integer reference model.
//  3. SIGNED_MODE=1, inputs 16'h8000 and 16'hFFFF -> negative=1 with
//     bcd_out 20'h32768 and 20'h00001; 16'h7FFF -> negative=0, 20'h32767.
//  4. DIGITS=4, input 16'd12345 -> overflow=1, bcd_out=16'h2345;
//     next conversion of 16'd42 -> overflow=0, 16'h0042.
//  5. Pulse start again at cycle 10 with a different input -> ignored, result
//     is the first operand. Hold start high through DONE -> second conversion
//     starts with no IDLE cycle, done again 33 cycles later.
//  6. Assert reset_n low at cycle 15 of a conversion -> busy=0, bcd_out=0,
//     no done pulse. After release, a fresh conversion completes correctly.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the add-3 correction constants.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADJUST = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0] ADD3_VALUE     = 4'd3;

endpackage

// File: rtl/bin2bcd_seq_digit_adjust.sv
// Combinational add-3 cell for one BCD digit of the double-dabble datapath.
module bcd_digit_adjust
  import bin2bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // A digit of 5..9 becomes 8..12, so the 4-bit sum never carries out.
  always_comb begin
    if (i_digit >= ADD3_THRESHOLD) begin
      o_digit = i_digit + ADD3_VALUE;
    end else begin
      o_digit = i_digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Self-sequenced shift-and-add-3 binary-to-BCD converter with start/done handshake,
// optional two's-complement input and overflow reporting for narrow digit counts.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_WIDTH   = 16,
  parameter int DIGITS      = 5,
  parameter int SIGNED_MODE = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  input_data,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [SR_W-1:0]      r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_sticky;
  logic                 r_sign;
  logic [BCD_W-1:0]     r_bcd_out;
  logic                 r_negative;
  logic                 r_overflow;

  logic [BCD_W-1:0]     w_adj_bcd;
  logic [SR_W-1:0]      w_shifted;
  logic                 w_shift_out;
  logic                 w_last_shift;
  logic                 w_accept;
  logic                 w_in_neg;
  logic [BIN_WIDTH-1:0] w_magnitude;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adj (
      .i_digit (r_sr[BIN_WIDTH + 4*g +: 4]),
      .o_digit (w_adj_bcd[4*g +: 4])
    );
  end

  assign w_shifted    = {r_sr[SR_W-2:0], 1'b0};
  assign w_shift_out  = r_sr[SR_W-1];
  assign w_last_shift = (r_cnt == CNT_W'(BIN_WIDTH - 1));
  assign w_accept     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_in_neg     = (SIGNED_MODE != 0) && input_data[BIN_WIDTH-1];

  // Negation in BIN_WIDTH unsigned bits keeps the most-negative value exact.
  always_comb begin
    if (w_in_neg) begin
      w_magnitude = (~input_data) + {{(BIN_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_magnitude = input_data;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = start ? ST_ADJUST : ST_IDLE;
      ST_ADJUST: w_next_state = ST_SHIFT;
      ST_SHIFT:  w_next_state = w_last_shift ? ST_DONE : ST_ADJUST;
      ST_DONE:   w_next_state = start ? ST_ADJUST : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_ADJUST, ST_SHIFT: busy = 1'b1;
      ST_DONE:             done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: load, adjust, shift; results publish only on the final shift.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sr         <= {SR_W{1'b0}};
      r_cnt        <= {CNT_W{1'b0}};
      r_ovf_sticky <= 1'b0;
      r_sign       <= 1'b0;
      r_bcd_out    <= {BCD_W{1'b0}};
      r_negative   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_sr         <= {{BCD_W{1'b0}}, w_magnitude};
            r_cnt        <= {CNT_W{1'b0}};
            r_ovf_sticky <= 1'b0;
            r_sign       <= w_in_neg;
          end
        end
        ST_ADJUST: begin
          r_sr <= {w_adj_bcd, r_sr[BIN_WIDTH-1:0]};
        end
        ST_SHIFT: begin
          r_sr         <= w_shifted;
          r_cnt        <= r_cnt + CNT_W'(1);
          r_ovf_sticky <= r_ovf_sticky | w_shift_out;
          if (w_last_shift) begin
            r_bcd_out  <= w_shifted[SR_W-1:BIN_WIDTH];
            r_overflow <= r_ovf_sticky | w_shift_out;
            r_negative <= r_sign;
          end
        end
        default: begin
          r_sr <= r_sr;
        end
      endcase
    end
  end

  assign bcd_out  = r_bcd_out;
  assign negative = r_negative;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: three parameterisations (default, signed, 4-digit) checked
// with a directed table, random operands against an arithmetic model, and handshake corners.
module tb_bin2bcd_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic [15:0] data_a [3];
  logic [2:0]  busy_v, done_v, neg_v, ovf_v;
  logic [19:0] bcd0, bcd1;
  logic [15:0] bcd2;
  logic [19:0] last_exp [3];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          k;
    logic [15:0] din;
    logic [19:0] exp_bcd;
    logic        exp_neg;
    logic        exp_ovf;
  } vec_t;

  always #5 clock = ~clock;

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED_MODE(0)) u_def (
    .clock(clock), .reset_n(reset_n), .start(start_v[0]), .input_data(data_a[0]),
    .busy(busy_v[0]), .done(done_v[0]), .bcd_out(bcd0), .negative(neg_v[0]), .overflow(ovf_v[0]));
  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED_MODE(1)) u_sgn (
    .clock(clock), .reset_n(reset_n), .start(start_v[1]), .input_data(data_a[1]),
    .busy(busy_v[1]), .done(done_v[1]), .bcd_out(bcd1), .negative(neg_v[1]), .overflow(ovf_v[1]));
  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(4), .SIGNED_MODE(0)) u_d4 (
    .clock(clock), .reset_n(reset_n), .start(start_v[2]), .input_data(data_a[2]),
    .busy(busy_v[2]), .done(done_v[2]), .bcd_out(bcd2), .negative(neg_v[2]), .overflow(ovf_v[2]));

  function automatic logic [19:0] bcd_of(input int k);
    case (k)
      0:       return bcd0;
      1:       return bcd1;
      default: return {4'h0, bcd2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decimal digits by repeated division; the reference for all random operands.
  function automatic logic [19:0] ref_digits(input int unsigned v, input int nd);
    logic [19:0] r = 20'h0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model(input int k, input logic [15:0] d,
                       output logic [19:0] b, output logic n, output logic o);
    int unsigned mag;
    int          nd;
    nd  = (k == 2) ? 4 : 5;
    n   = (k == 1) && d[15];
    mag = n ? (32'd65536 - 32'(d)) : 32'(d);
    o   = (nd == 4) ? (mag > 32'd9999) : (mag > 32'd99999);
    b   = ref_digits(mag, nd);
  endtask

  task automatic convert(input int k, input logic [15:0] d, input int intr_cyc,
                         input logic [15:0] intr_d, input bit no_wait,
                         output int lat, output int bad_busy, output int bad_hold);
    if (!no_wait) @(negedge clock);
    data_a[k]  = d;
    start_v[k] = 1'b1;
    @(negedge clock);
    start_v[k] = 1'b0;
    data_a[k]  = 16'($urandom);
    lat = 1; bad_busy = 0; bad_hold = 0;
    while (lat < 100 && !done_v[k]) begin
      if (!busy_v[k]) bad_busy++;
      if (bcd_of(k) !== last_exp[k]) bad_hold++;
      if (lat == intr_cyc) begin
        start_v[k] = 1'b1;
        data_a[k]  = intr_d;
      end else begin
        start_v[k] = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    start_v[k] = 1'b0;
  endtask

  task automatic run_and_check(input string name, input int k, input logic [15:0] d,
                               input logic [19:0] eb, input logic en, input logic eo,
                               input int intr_cyc, input logic [15:0] intr_d, input bit no_wait);
    int lat, bb, bh;
    convert(k, d, intr_cyc, intr_d, no_wait, lat, bb, bh);
    check({name, ".bcd"}, 32'(bcd_of(k)), 32'(eb));
    check({name, ".neg"}, 32'(neg_v[k]), 32'(en));
    check({name, ".ovf"}, 32'(ovf_v[k]), 32'(eo));
    check({name, ".latency"}, 32'(lat), 32'd33);
    check({name, ".busy_gaps"}, 32'(bb), 32'd0);
    check({name, ".hold_changes"}, 32'(bh), 32'd0);
    last_exp[k] = eb;
  endtask

  initial begin
    vec_t        vecs [12];
    logic [19:0] eb;
    logic        en, eo;
    logic [15:0] d;
    int          done_seen;

    vecs[0]  = '{0, 16'd65535, 20'h65535, 1'b0, 1'b0};
    vecs[1]  = '{0, 16'd0,     20'h00000, 1'b0, 1'b0};
    vecs[2]  = '{0, 16'd9,     20'h00009, 1'b0, 1'b0};
    vecs[3]  = '{0, 16'd10,    20'h00010, 1'b0, 1'b0};
    vecs[4]  = '{0, 16'd9999,  20'h09999, 1'b0, 1'b0};
    vecs[5]  = '{1, 16'h8000,  20'h32768, 1'b1, 1'b0};
    vecs[6]  = '{1, 16'hFFFF,  20'h00001, 1'b1, 1'b0};
    vecs[7]  = '{1, 16'h7FFF,  20'h32767, 1'b0, 1'b0};
    vecs[8]  = '{2, 16'd12345, 20'h02345, 1'b0, 1'b1};
    vecs[9]  = '{2, 16'd42,    20'h00042, 1'b0, 1'b0};
    vecs[10] = '{2, 16'd9999,  20'h09999, 1'b0, 1'b0};
    vecs[11] = '{2, 16'd10000, 20'h00000, 1'b0, 1'b1};

    for (int k = 0; k < 3; k++) begin
      data_a[k]   = 16'h0;
      last_exp[k] = 20'h0;
    end

    #12;
    check("reset.busy", 32'(busy_v), 32'd0);
    check("reset.done", 32'(done_v), 32'd0);
    check("reset.bcd0", 32'(bcd0), 32'd0);
    check("reset.flags", 32'({neg_v, ovf_v}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].k, vecs[i].din,
                    vecs[i].exp_bcd, vecs[i].exp_neg, vecs[i].exp_ovf, 0, 16'h0, 1'b0);
      if (i == 0) begin
        @(negedge clock);
        check("done_one_cycle", 32'(done_v[0]), 32'd0);
      end
    end

    for (int i = 0; i < 30; i++) begin
      int k;
      k = i % 3;
      d = 16'($urandom);
      model(k, d, eb, en, eo);
      run_and_check($sformatf("rand%0d", i), k, d, eb, en, eo, 0, 16'h0, 1'b0);
    end

    // Start pulse at cycle 10 while busy must be ignored.
    run_and_check("ignore_busy_start", 0, 16'd1234, 20'h01234, 1'b0, 1'b0, 10, 16'd4321, 1'b0);

    // Back-to-back: second start raised during the DONE cycle itself.
    run_and_check("chain_a", 0, 16'd111, 20'h00111, 1'b0, 1'b0, 0, 16'h0, 1'b0);
    run_and_check("chain_b", 0, 16'd50000, 20'h50000, 1'b0, 1'b0, 0, 16'h0, 1'b1);

    // Reset mid-conversion at cycle 15.
    @(negedge clock);
    data_a[0]  = 16'd7777;
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midreset.busy", 32'(busy_v[0]), 32'd0);
    check("midreset.bcd", 32'(bcd0), 32'd0);
    check("midreset.done", 32'(done_v[0]), 32'd0);
    for (int k = 0; k < 3; k++) last_exp[k] = 20'h0;
    @(negedge clock);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done_v[0]) done_seen++;
    end
    check("midreset.no_done", 32'(done_seen), 32'd0);
    run_and_check("after_reset", 0, 16'd4321, 20'h04321, 1'b0, 1'b0, 0, 16'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
